// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte image and writes it
// word by word into instruction memory, releasing the CPU from reset only on success.
module imem_boot_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  err,
    output logic [9:0]            word_count
);

    typedef enum logic [2:0] {
        StIdle, StLenLo, StLenHi, StData, StWrite, StCsum, StDone, StErr
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              len_lo_q, len_lo_d;
    logic [15:0]             len_q, len_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [7:0]              csum_q, csum_d;
    logic [9:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    rx_ready_q, wr_en_q, cpu_reset_q, done_q, err_q;
    logic                    accept;
    logic [15:0]             n_hdr;

    assign accept = rx_ready_q & rx_valid;
    assign n_hdr  = {rx_data, len_lo_q};

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        csum_d     = csum_q;
        cnt_d      = cnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d    = StLenLo;
                    byte_idx_d = 2'd0;
                    csum_d     = 8'd0;
                    cnt_d      = 10'd0;
                    word_d     = '0;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_lo_d = rx_data;
                    state_d  = StLenHi;
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d = n_hdr;
                    if ((n_hdr == 16'd0) || (32'(n_hdr) > MEM_SIZE)) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
                    csum_d     = csum_q ^ rx_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Latch the write beat here so addr/data only move when wr_en rises.
                        state_d   = StWrite;
                        wr_addr_d = ADDR_WIDTH'({cnt_q, 2'b00});
                        wr_data_d = word_d;
                    end
                end
            end
            StWrite: begin
                cnt_d = cnt_q + 10'd1;
                if ((16'(cnt_q) + 16'd1) == len_q) begin
                    state_d = StCsum;
                end else begin
                    state_d = StData;
                end
            end
            StCsum: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_lo_q    <= 8'd0;
            len_q       <= 16'd0;
            byte_idx_q  <= 2'd0;
            word_q      <= '0;
            csum_q      <= 8'd0;
            cnt_q       <= 10'd0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rx_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            csum_q      <= csum_d;
            cnt_q       <= cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rx_ready_q  <= (state_d == StLenLo) || (state_d == StLenHi) ||
                           (state_d == StData)  || (state_d == StCsum);
            wr_en_q     <= (state_d == StWrite);
            cpu_reset_q <= (state_d != StDone);
            done_q      <= (state_d == StDone);
            err_q       <= (state_d == StErr);
        end
    end

    assign rx_ready   = rx_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: a byte-stream model predicts the memory writes
// and the final outcome; a monitor pops expected writes whenever wr_en is seen.
module tb_imem_boot_loader;

    localparam int MEM_SIZE = 512;
    localparam int BOUND    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, wr_en, cpu_reset, done, err;
    logic [31:0] wr_addr, wr_data;
    logic [9:0]  word_count;

    imem_boot_loader #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .MEM_SIZE  (MEM_SIZE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  img[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    initial begin
        logic [31:0] a, d;
        forever begin
            @(negedge clk);
            if (rst_n && wr_en) begin
                chk("rx_ready_in_write", 32'(rx_ready), 32'd0);
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                             wr_addr, wr_data);
                end else begin
                    a = exp_addr.pop_front();
                    d = exp_data.pop_front();
                    chk("wr_addr", wr_addr, a);
                    chk("wr_data", wr_data, d);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
        chk({tag, "_wr_addr"}, wr_addr, 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
    endtask

    // Called and returns at a falling edge.
    task automatic start_pulse();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_err", 32'(err), 32'd0);
        chk("restart_rx_ready", 32'(rx_ready), 32'd1);
        chk("restart_word_count", 32'(word_count), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (!rx_ready && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!rx_ready) begin
            errors++;
            $display("FAIL byte_accept_timeout: got no rx_ready expected accept of 0x%0h", b);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    // Reference model: parse the image by the format rules, predict writes and outcome.
    task automatic run_image(input logic [7:0] s[$], input int maxgap);
        int         n, nsend, ecnt;
        logic [7:0] x;
        logic [31:0] w;
        bit         exp_done;
        n = int'(s[0]) | (int'(s[1]) << 8);
        if (n == 0 || n > MEM_SIZE) begin
            exp_done = 1'b0;
            nsend    = 2;
            ecnt     = 0;
        end else begin
            x = 8'd0;
            for (int i = 0; i < n; i++) begin
                w = 32'd0;
                for (int k = 0; k < 4; k++) begin
                    w = w | (32'(s[2 + 4 * i + k]) << (8 * k));
                    x = x ^ s[2 + 4 * i + k];
                end
                exp_addr.push_back(32'(4 * i));
                exp_data.push_back(w);
            end
            exp_done = (s[2 + 4 * n] == x);
            nsend    = 2 + 4 * n + 1;
            ecnt     = n;
        end
        start_pulse();
        for (int j = 0; j < nsend; j++) begin
            send_byte(s[j], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
        end
        rx_valid = 1'b0;
        chk("final_done", 32'(done), 32'(exp_done));
        chk("final_err", 32'(err), 32'(!exp_done));
        chk("final_cpu_reset", 32'(cpu_reset), 32'(!exp_done));
        chk("final_rx_ready", 32'(rx_ready), 32'd0);
        chk("final_word_count", 32'(word_count), 32'(ecnt));
        chk("missing_writes", 32'(exp_addr.size()), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        @(negedge clk);
        chk("hold_word_count", 32'(word_count), 32'(ecnt));
    endtask

    task automatic make_image(input int n, input bit corrupt);
        logic [7:0] b, x;
        img.delete();
        img.push_back(8'(n));
        img.push_back(8'(n >> 8));
        x = 8'd0;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            img.push_back(b);
            x = x ^ b;
        end
        img.push_back(corrupt ? (x ^ (8'd1 << $urandom_range(7, 0))) : x);
    endtask

    initial begin
        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start    = 1'($urandom);
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            #1;
            check_reset_outputs("reset");
        end
        start    = 1'b0;
        rx_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_rx_ready", 32'(rx_ready), 32'd0);
        chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("idle_done", 32'(done), 32'd0);
        rx_valid = 1'b0;

        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
        run_image(img, 2);
        img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
        run_image(img, 1);
        img = '{8'h01, 8'h02};
        run_image(img, 0);
        img = '{8'h00, 8'h00};
        run_image(img, 0);

        // Continuous rx_valid: bytes offered during WRITE must wait.
        make_image(6, 1'b0);
        run_image(img, 0);

        for (int t = 0; t < 10; t++) begin
            make_image(int'($urandom_range(8, 1)), ($urandom_range(3, 0) == 0));
            run_image(img, 3);
        end

        // Reset after two data bytes, then a full fresh image.
        start_pulse();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs("midword_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 32'(rx_ready), 32'd0);
        make_image(3, 1'b0);
        run_image(img, 1);

        // Largest image that fits.
        make_image(MEM_SIZE, 1'b0);
        run_image(img, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
